// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch stage.
// fetch_entry_t is the {pc, instr} pair for the default 32/32 configuration.
// The queue takes its entry type as a parameter, so other widths remain possible.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Byte distance between consecutive instructions.
    function automatic int pc_inc(input int data_w);
        return data_w / 32'sd8;
    endfunction

    // Pointer width for a power-of-two queue; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: a synchronous FIFO of fetch entries.
// flush empties the queue and overrides push and pop on the same cycle.
// A push while full is accepted only when a pop frees a slot on that cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  entry_t             din,
    output entry_t             head,
    output logic [ptr_w(DEPTH):0] count
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against occupancy; flush suppresses both.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (flush) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            pop_ok_s  = pop && (count_r != '0);
            push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
        end
    end

    // Entry storage; contents need no reset because count guards visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and issues sequential reads to a
// synchronous instruction memory with one-cycle latency. Returned {pc, instr}
// pairs are buffered in a prefetch queue and handed to decode over valid/ready.
// A redirect flushes the queue, drops the response returning that cycle, and
// restarts fetch at the new, instruction-aligned PC.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched/perf_squashed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_vld,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_vld,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed
`endif
);

    localparam int PC_INC = pc_inc(DATA_W);
    localparam int PTR_W  = ptr_w(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_INC - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] flight_addr_r;
    logic              inflight_r;
    logic [PTR_W:0]    count_s;
    logic              credit_ok_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              vld_s;
    entry_t            din_s;
    entry_t            head_s;

    // Issue, return and handshake decisions for the current cycle.
    always_comb begin
        credit_ok_s = ({1'b0, count_s} + {{(PTR_W+1){1'b0}}, inflight_r})
                      < (PTR_W+2)'(DEPTH);
        issue_s = 1'b0;
        push_s  = 1'b0;
        vld_s   = 1'b0;
        if (reset || redirect_vld) begin
            issue_s = 1'b0;
            push_s  = 1'b0;
            vld_s   = 1'b0;
        end else begin
            issue_s = credit_ok_s;
            push_s  = inflight_r;
            vld_s   = (count_s != '0);
        end
        pop_s        = vld_s && out_rdy;
        din_s.pc     = flight_addr_r;
        din_s.instr  = imem_rdata;
    end

    // PC, in-flight flag and the address of the outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            flight_addr_r <= '0;
        end else if (redirect_vld) begin
            pc_r          <= redirect_pc & ALIGN_MASK;
            inflight_r    <= 1'b0;
            flight_addr_r <= flight_addr_r;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r          <= pc_r + ADDR_W'(PC_INC);
                flight_addr_r <= pc_r;
            end
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_vld),
        .push  (push_s),
        .pop   (pop_s),
        .din   (din_s),
        .head  (head_s),
        .count (count_s)
    );

    assign imem_req_vld = issue_s;
    assign imem_addr    = pc_r;
    assign out_vld      = vld_s;
    assign out_pc       = head_s.pc;
    assign out_instr    = head_s.instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_squashed_r;

    // Handshake count and count of work discarded by redirects (queued plus in flight).
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_r  <= 32'd0;
            perf_squashed_r <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if (redirect_vld) begin
                perf_squashed_r <= perf_squashed_r + 32'(count_s) + 32'(inflight_r);
            end
        end
    end

    assign perf_fetched  = perf_fetched_r;
    assign perf_squashed = perf_squashed_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=4, 32-bit, RESET_PC=0).
// The instruction memory model returns instr_of(addr) one cycle after a request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_vld;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'd0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .imem_req_vld (imem_req_vld),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_pc       (out_pc),
        .out_instr    (out_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hDEAD_BEEF;
    endfunction

    // Synchronous memory: data for a request appears on the next cycle.
    always @(posedge clk) begin
        if (imem_req_vld) imem_rdata <= instr_of(imem_addr);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_vld = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        out_rdy = 1'b1;
        reset = 1'b1;
        cyc();
        cyc();
        #1;
        n_cmp++;
        if (imem_req_vld !== 1'b0 || out_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got req=%b vld=%b exp req=0 vld=0", imem_req_vld, out_vld);
        end
        cyc();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_vld !== 1'b1 || imem_addr !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_first_issue got req=%b addr=%h exp req=1 addr=0", imem_req_vld, imem_addr);
        end
        cyc();
    endtask

    task automatic test_stream();
        out_rdy = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            n_cmp++;
            if (imem_req_vld !== 1'b1 || imem_addr !== 32'(4*k)) begin
                n_bad++;
                $display("FAIL stream_issue[%0d] got req=%b addr=%h exp addr=%h", k, imem_req_vld, imem_addr, 32'(4*k));
            end
            n_cmp++;
            if (k < 2) begin
                if (out_vld !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stream_latency[%0d] got vld=%b exp 0", k, out_vld);
                end
            end else if (out_vld !== 1'b1 || out_pc !== 32'(4*(k-2)) || out_instr !== instr_of(32'(4*(k-2)))) begin
                n_bad++;
                $display("FAIL stream_out[%0d] got vld=%b pc=%h exp pc=%h", k, out_vld, out_pc, 32'(4*(k-2)));
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int          got;
        logic        first_issue;
        out_rdy = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if (imem_req_vld !== (k < 4) || (k < 4 && imem_addr !== 32'(4*k))) begin
                n_bad++;
                $display("FAIL bp_issue[%0d] got req=%b addr=%h exp req=%b", k, imem_req_vld, imem_addr, (k < 4));
            end
            if (k >= 2) begin
                n_cmp++;
                if (out_vld !== 1'b1 || out_pc !== 32'd0) begin
                    n_bad++;
                    $display("FAIL bp_hold[%0d] got vld=%b pc=%h exp vld=1 pc=0", k, out_vld, out_pc);
                end
            end
            cyc();
        end
        out_rdy = 1'b1;
        exp_pc = 32'd0;
        got = 0;
        first_issue = 1'b1;
        for (int k = 0; k < 20 && got < 5; k++) begin
            #1;
            if (imem_req_vld && first_issue) begin
                first_issue = 1'b0;
                n_cmp++;
                if (imem_addr !== 32'h10) begin
                    n_bad++;
                    $display("FAIL bp_resume_addr got %h exp 00000010", imem_addr);
                end
            end
            if (out_vld) begin
                n_cmp++;
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                    n_bad++;
                    $display("FAIL bp_drain got pc=%h exp pc=%h", out_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            cyc();
        end
        n_cmp++;
        if (got != 5) begin
            n_bad++;
            $display("FAIL bp_drain_count got %0d exp 5", got);
        end
    endtask

    task automatic test_redirect();
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] sq0;
`endif
        out_rdy = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) cyc();
        out_rdy = 1'b1;
        #1;
        n_cmp++;
        if (out_vld !== 1'b1 || out_pc !== 32'd0 || imem_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_full got vld=%b pc=%h req=%b exp vld=1 pc=0 req=0", out_vld, out_pc, imem_req_vld);
        end
        cyc();
        out_rdy = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_vld !== 1'b1 || imem_addr !== 32'h10) begin
            n_bad++;
            $display("FAIL redir_inflight got req=%b addr=%h exp req=1 addr=10", imem_req_vld, imem_addr);
        end
        cyc();
        redirect_vld = 1'b1;
        redirect_pc = 32'h103;
        out_rdy = 1'b1;
        #1;
`ifdef FETCH_PERF_CNT_EN
        sq0 = perf_squashed;
`endif
        n_cmp++;
        if (out_vld !== 1'b0 || imem_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_cycle got vld=%b req=%b exp 0 0", out_vld, imem_req_vld);
        end
        cyc();
        redirect_vld = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_vld !== 1'b1 || imem_addr !== 32'h100 || out_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_issue got req=%b addr=%h vld=%b exp addr=100 vld=0", imem_req_vld, imem_addr, out_vld);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (perf_squashed !== sq0 + 32'd4) begin
            n_bad++;
            $display("FAIL redir_squash_cnt got %0d exp %0d", perf_squashed, sq0 + 32'd4);
        end
`endif
        cyc();
        #1;
        n_cmp++;
        if (out_vld !== 1'b0 || imem_addr !== 32'h104) begin
            n_bad++;
            $display("FAIL redir_write got vld=%b addr=%h exp vld=0 addr=104", out_vld, imem_addr);
        end
        cyc();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (out_vld !== 1'b1 || out_pc !== 32'h100 + 32'(4*k) || out_instr !== instr_of(32'h100 + 32'(4*k))) begin
                n_bad++;
                $display("FAIL redir_out[%0d] got vld=%b pc=%h exp pc=%h", k, out_vld, out_pc, 32'h100 + 32'(4*k));
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) cyc();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_vld !== 1'b0 || imem_req_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_cycle got vld=%b req=%b exp 0 0", out_vld, imem_req_vld);
        end
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (k < 2 && (out_vld !== 1'b0 || imem_addr !== 32'(4*k))) begin
                n_bad++;
                $display("FAIL mid_restart[%0d] got vld=%b addr=%h exp vld=0 addr=%h", k, out_vld, imem_addr, 32'(4*k));
            end else if (k == 2 && (out_vld !== 1'b1 || out_pc !== 32'd0)) begin
                n_bad++;
                $display("FAIL mid_first_out got vld=%b pc=%h exp vld=1 pc=0", out_vld, out_pc);
            end
            cyc();
        end
    endtask

    task automatic test_wrap();
        out_rdy = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect_vld = 1'b0;
        #1;
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_first got %h exp fffffffc", imem_addr);
        end
        cyc();
        #1;
        n_cmp++;
        if (imem_req_vld !== 1'b1 || imem_addr !== 32'd0) begin
            n_bad++;
            $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=0", imem_req_vld, imem_addr);
        end
        cyc();
        #1;
        n_cmp++;
        if (out_vld !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_out0 got vld=%b pc=%h exp fffffffc", out_vld, out_pc);
        end
        cyc();
        #1;
        n_cmp++;
        if (out_vld !== 1'b1 || out_pc !== 32'd0 || out_instr !== instr_of(32'd0)) begin
            n_bad++;
            $display("FAIL wrap_out1 got vld=%b pc=%h exp 0", out_vld, out_pc);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic        do_redir;
        int          hs;
        exp_pc = 32'd0;
        hs = 0;
        for (int k = 0; k < 400; k++) begin
            do_redir = (k == 0) || ($urandom_range(0, 19) == 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            if (do_redir) begin
                redirect_vld = 1'b1;
                redirect_pc = $urandom & 32'h0000_FFFF;
            end
            #1;
            if (do_redir) begin
                n_cmp++;
                if (out_vld !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_redir_vld[%0d] got %b exp 0", k, out_vld);
                end
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (out_vld && out_rdy) begin
                n_cmp++;
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                    n_bad++;
                    $display("FAIL rand_deliver[%0d] got pc=%h instr=%h exp pc=%h", k, out_pc, out_instr, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                hs++;
            end
            cyc();
            redirect_vld = 1'b0;
        end
        n_cmp++;
        if (hs < 50) begin
            n_bad++;
            $display("FAIL rand_throughput got %0d handshakes exp >= 50", hs);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
